// File: rtl/mc_fifo_pkg.sv
// Shared helpers for mc_fifo: channel-index and pointer widths, and the
// extra-MSB pointer compares that produce full/empty.
package mc_fifo_pkg;

    typedef logic [31:0] ptr_word_t;

    function automatic int chan_idx_w(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    function automatic int ptr_w(input int log_depth);
        return log_depth + 1;
    endfunction

    // Equal pointers mean empty; only the extra MSB differing means full.
    function automatic logic ptr_full(input ptr_word_t wptr, input ptr_word_t rptr,
                                      input int log_depth);
        ptr_word_t mask;
        mask = (32'd1 << (log_depth + 1)) - 32'd1;
        return ((wptr ^ rptr) & mask) == (32'd1 << log_depth);
    endfunction

    function automatic logic ptr_empty(input ptr_word_t wptr, input ptr_word_t rptr,
                                       input int log_depth);
        ptr_word_t mask;
        mask = (32'd1 << (log_depth + 1)) - 32'd1;
        return ((wptr ^ rptr) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/mc_fifo_chan_ctrl.sv
// Per-channel pointer pair for mc_fifo: flush/push/pop bookkeeping, flags and
// storage addresses. Optional usage_o port under MC_FIFO_USAGE_EN.
module mc_fifo_chan_ctrl
    import mc_fifo_pkg::*;
#(
    parameter int LOG_DEPTH = 2,
    parameter int CW        = 2,
    parameter int CHAN      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [CW+LOG_DEPTH-1:0] waddr_o,
    output logic [CW+LOG_DEPTH-1:0] raddr_o
`ifdef MC_FIFO_USAGE_EN
    ,
    output logic [LOG_DEPTH:0]      usage_o
`endif
);

    localparam int PW = ptr_w(LOG_DEPTH);
    localparam logic [CW-1:0] CHAN_IDX = CW'(CHAN);

    logic [PW-1:0] wptr_q;
    logic [PW-1:0] wptr_d;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rptr_d;

    // Next pointers: flush clears both and wins over any handshake.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PW'(1);
            else        wptr_d = wptr_q;
            if (pop_i)  rptr_d = rptr_q + PW'(1);
            else        rptr_d = rptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign full_o  = ptr_full(32'(wptr_q), 32'(rptr_q), LOG_DEPTH);
    assign empty_o = ptr_empty(32'(wptr_q), 32'(rptr_q), LOG_DEPTH);
    assign waddr_o = {CHAN_IDX, wptr_q[LOG_DEPTH-1:0]};
    assign raddr_o = {CHAN_IDX, rptr_q[LOG_DEPTH-1:0]};

`ifdef MC_FIFO_USAGE_EN
    assign usage_o = wptr_q - rptr_q;
`endif

endmodule

// File: rtl/mc_fifo_sva.sv
// Simulation checks for mc_fifo handshakes and configuration.
module mc_fifo_sva #(
    parameter int LOG_DEPTH = 2
) (
    input logic clk_i,
    input logic rst_i,
    input logic push_i,
    input logic pop_i,
    input logic full_i,
    input logic empty_i
);

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_i));
    a_log_depth:    assert property (@(posedge clk_i) LOG_DEPTH > 0);

endmodule

// File: rtl/mc_fifo.sv
// Single-clock multi-channel FIFO: shared register storage, one steered write
// port, one consumer-selected read port. MC_FIFO_USAGE_EN adds usage_o.
module mc_fifo
    import mc_fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LOG_DEPTH    = 2,
    parameter int FALL_THROUGH = 0,
    localparam int CW          = chan_idx_w(NUM_CHANNELS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CW-1:0]           in_chan_i,
    input  logic [WIDTH-1:0]        in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [CW-1:0]           out_chan_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    input  logic [NUM_CHANNELS-1:0] flush_i,
    output logic [NUM_CHANNELS-1:0] full_o,
    output logic [NUM_CHANNELS-1:0] empty_o
`ifdef MC_FIFO_USAGE_EN
    ,
    output logic [NUM_CHANNELS*(LOG_DEPTH+1)-1:0] usage_o
`endif
);

    localparam int AW    = CW + LOG_DEPTH;
    localparam int NSLOT = 1 << CW;
    localparam logic [CW:0] NCH = (CW+1)'(NUM_CHANNELS);
    localparam logic FT_EN = (FALL_THROUGH != 0);

    logic [WIDTH-1:0] mem_q [1 << AW];

    logic [NUM_CHANNELS-1:0] full_s;
    logic [NUM_CHANNELS-1:0] empty_s;
    logic [NUM_CHANNELS-1:0] push_vec_s;
    logic [NUM_CHANNELS-1:0] pop_vec_s;
    logic [AW-1:0]           waddr_s [NUM_CHANNELS];
    logic [AW-1:0]           raddr_s [NUM_CHANNELS];

    logic [NSLOT-1:0]         full_pad_s;
    logic [NSLOT-1:0]         empty_pad_s;
    logic [NSLOT-1:0]         flush_pad_s;
    logic [NSLOT-1:0][AW-1:0] waddr_pad_s;
    logic [NSLOT-1:0][AW-1:0] raddr_pad_s;

    logic             in_ok_s;
    logic             out_ok_s;
    logic             in_ready_s;
    logic             out_avail_s;
    logic             ft_s;
    logic             push_s;
    logic             pop_s;
    logic             sel_full_s;
    logic             sel_empty_s;
    logic [WIDTH-1:0] out_data_s;

    assign in_ok_s  = ({1'b0, in_chan_i} < NCH);
    assign out_ok_s = ({1'b0, out_chan_i} < NCH);

    // Unused index slots read as full/empty/flushed so they can never handshake.
    always_comb begin
        full_pad_s  = '1;
        empty_pad_s = '1;
        flush_pad_s = '1;
        waddr_pad_s = '0;
        raddr_pad_s = '0;
        full_pad_s[NUM_CHANNELS-1:0]  = full_s;
        empty_pad_s[NUM_CHANNELS-1:0] = empty_s;
        flush_pad_s[NUM_CHANNELS-1:0] = flush_i;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            waddr_pad_s[c] = waddr_s[c];
            raddr_pad_s[c] = raddr_s[c];
        end
    end

    // Handshakes; in_ready never looks at out_ready, so a full channel stays
    // closed even when it is being popped in the same cycle.
    always_comb begin
        sel_full_s  = full_pad_s[in_chan_i];
        sel_empty_s = empty_pad_s[out_chan_i];
        in_ready_s  = in_ok_s & ~sel_full_s & ~flush_pad_s[in_chan_i];
        out_avail_s = out_ok_s & ~sel_empty_s & ~flush_pad_s[out_chan_i];
        ft_s        = FT_EN & in_valid_i & in_ready_s & (in_chan_i == out_chan_i) & sel_empty_s;
        push_s      = in_valid_i & in_ready_s & ~(ft_s & out_ready_i);
        pop_s       = out_avail_s & out_ready_i;
        if (ft_s) out_data_s = in_data_i;
        else      out_data_s = mem_q[raddr_pad_s[out_chan_i]];
    end

    always_ff @(posedge clk_i) begin
        if (push_s) mem_q[waddr_pad_s[in_chan_i]] <= in_data_i;
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        assign push_vec_s[c] = push_s & (in_chan_i == CW'(c));
        assign pop_vec_s[c]  = pop_s & (out_chan_i == CW'(c));

        mc_fifo_chan_ctrl #(
            .LOG_DEPTH (LOG_DEPTH),
            .CW        (CW),
            .CHAN      (c)
        ) u_ctrl (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i[c]),
            .push_i  (push_vec_s[c]),
            .pop_i   (pop_vec_s[c]),
            .full_o  (full_s[c]),
            .empty_o (empty_s[c]),
            .waddr_o (waddr_s[c]),
            .raddr_o (raddr_s[c])
`ifdef MC_FIFO_USAGE_EN
            ,
            .usage_o (usage_o[c*(LOG_DEPTH+1) +: LOG_DEPTH+1])
`endif
        );
    end

    mc_fifo_sva #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_sva (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .full_i  (sel_full_s),
        .empty_i (sel_empty_s)
    );

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_avail_s | ft_s;
    assign out_data_o  = out_data_s;
    assign full_o      = full_s;
    assign empty_o     = empty_s;

endmodule

// File: tb/tb_mc_fifo.sv
// Bench for mc_fifo: directed vector tables for a 4-channel buffered instance
// and a 3-channel fall-through instance, then randomized traffic vs a queue model.
module tb_mc_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 channels, depth 4, registered read path
    logic       a_rst, a_iv, a_ir, a_ov, a_or;
    logic [1:0] a_ic, a_oc;
    logic [7:0] a_id, a_od;
    logic [3:0] a_fl, a_full, a_empty;

    // Instance B: 3 channels, depth 4, fall-through
    logic       b_rst, b_iv, b_ir, b_ov, b_or;
    logic [1:0] b_ic, b_oc;
    logic [7:0] b_id, b_od;
    logic [2:0] b_fl, b_full, b_empty;

    mc_fifo #(.WIDTH(8), .NUM_CHANNELS(4), .LOG_DEPTH(2), .FALL_THROUGH(0)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .in_chan_i(a_ic), .in_data_i(a_id), .in_valid_i(a_iv),
        .in_ready_o(a_ir), .out_chan_i(a_oc), .out_data_o(a_od), .out_valid_o(a_ov),
        .out_ready_i(a_or), .flush_i(a_fl), .full_o(a_full), .empty_o(a_empty));

    mc_fifo #(.WIDTH(8), .NUM_CHANNELS(3), .LOG_DEPTH(2), .FALL_THROUGH(1)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .in_chan_i(b_ic), .in_data_i(b_id), .in_valid_i(b_iv),
        .in_ready_o(b_ir), .out_chan_i(b_oc), .out_data_o(b_od), .out_valid_o(b_ov),
        .out_ready_i(b_or), .flush_i(b_fl), .full_o(b_full), .empty_o(b_empty));

    typedef struct {
        logic       rst, chk, iv;
        logic [1:0] ic;
        logic [7:0] id;
        logic [1:0] oc;
        logic       orr;
        logic [3:0] fl;
        logic       ir, ov;
        logic [7:0] od;
        logic [3:0] full, empty;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tab_a[$];
    vec_t tab_b[$];
    logic [7:0] q[4][$];

    function automatic vec_t v(input logic rst, input logic chk, input logic iv, input logic [1:0] ic,
                               input logic [7:0] id, input logic [1:0] oc, input logic orr,
                               input logic [3:0] fl, input logic ir, input logic ov,
                               input logic [7:0] od, input logic [3:0] full, input logic [3:0] empty);
        vec_t t;
        t.rst = rst; t.chk = chk; t.iv = iv; t.ic = ic; t.id = id; t.oc = oc; t.orr = orr;
        t.fl = fl; t.ir = ir; t.ov = ov; t.od = od; t.full = full; t.empty = empty;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare settled outputs, then cross the edge.
    task automatic run(input int d, input vec_t t, input string tag);
        logic ir, ov;
        logic [7:0] od;
        logic [3:0] full, empty;
        if (d == 0) begin
            a_rst = t.rst; a_iv = t.iv; a_ic = t.ic; a_id = t.id; a_oc = t.oc; a_or = t.orr; a_fl = t.fl;
        end else begin
            b_rst = t.rst; b_iv = t.iv; b_ic = t.ic; b_id = t.id; b_oc = t.oc; b_or = t.orr; b_fl = t.fl[2:0];
        end
        #1;
        if (d == 0) begin
            ir = a_ir; ov = a_ov; od = a_od; full = a_full; empty = a_empty;
        end else begin
            ir = b_ir; ov = b_ov; od = b_od; full = {1'b0, b_full}; empty = {1'b0, b_empty};
        end
        if (t.chk) begin
            chk({tag, ".in_ready"}, 32'(ir), 32'(t.ir));
            chk({tag, ".out_valid"}, 32'(ov), 32'(t.ov));
            if (t.ov) chk({tag, ".out_data"}, 32'(od), 32'(t.od));
            chk({tag, ".full"}, 32'(full), 32'(t.full));
            chk({tag, ".empty"}, 32'(empty), 32'(t.empty));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        b_rst = 1'b1; b_iv = 1'b0; b_ic = '0; b_id = '0; b_oc = '0; b_or = 1'b0; b_fl = '0;

        //            rst chk iv ic id     oc or fl    ir ov od     full   empty
        tab_a.push_back(v(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0));
        tab_a.push_back(v(0, 1, 0, 1, 8'h00, 1, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF));
        tab_a.push_back(v(0, 1, 1, 1, 8'h11, 1, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF));
        tab_a.push_back(v(0, 1, 1, 1, 8'h22, 1, 0, 4'h0, 1, 1, 8'h11, 4'h0, 4'hD));
        tab_a.push_back(v(0, 1, 1, 1, 8'h33, 1, 0, 4'h0, 1, 1, 8'h11, 4'h0, 4'hD));
        tab_a.push_back(v(0, 1, 1, 1, 8'h44, 1, 0, 4'h0, 1, 1, 8'h11, 4'h0, 4'hD));
        tab_a.push_back(v(0, 1, 1, 1, 8'h55, 1, 0, 4'h0, 0, 1, 8'h11, 4'h2, 4'hD));
        tab_a.push_back(v(0, 1, 1, 1, 8'h55, 1, 1, 4'h0, 0, 1, 8'h11, 4'h2, 4'hD));
        tab_a.push_back(v(0, 1, 0, 1, 8'h00, 1, 1, 4'h0, 1, 1, 8'h22, 4'h0, 4'hD));
        tab_a.push_back(v(0, 1, 0, 1, 8'h00, 1, 1, 4'h0, 1, 1, 8'h33, 4'h0, 4'hD));
        tab_a.push_back(v(0, 1, 0, 1, 8'h00, 1, 1, 4'h0, 1, 1, 8'h44, 4'h0, 4'hD));
        tab_a.push_back(v(0, 1, 0, 1, 8'h00, 1, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF));
        tab_a.push_back(v(0, 1, 1, 0, 8'hA0, 0, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF));
        tab_a.push_back(v(0, 1, 1, 3, 8'hA3, 0, 0, 4'h0, 1, 1, 8'hA0, 4'h0, 4'hE));
        tab_a.push_back(v(0, 1, 1, 0, 8'hB0, 3, 0, 4'h0, 1, 1, 8'hA3, 4'h0, 4'h6));
        tab_a.push_back(v(0, 1, 0, 0, 8'h00, 3, 1, 4'h0, 1, 1, 8'hA3, 4'h0, 4'h6));
        tab_a.push_back(v(0, 1, 0, 0, 8'h00, 0, 1, 4'h0, 1, 1, 8'hA0, 4'h0, 4'hE));
        tab_a.push_back(v(0, 1, 0, 0, 8'h00, 0, 1, 4'h0, 1, 1, 8'hB0, 4'h0, 4'hE));
        tab_a.push_back(v(0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF));
        tab_a.push_back(v(0, 1, 1, 2, 8'h61, 2, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF));
        tab_a.push_back(v(0, 1, 1, 2, 8'h62, 2, 0, 4'h0, 1, 1, 8'h61, 4'h0, 4'hB));
        tab_a.push_back(v(0, 1, 1, 2, 8'h77, 2, 1, 4'h0, 1, 1, 8'h61, 4'h0, 4'hB));
        tab_a.push_back(v(0, 1, 0, 2, 8'h00, 2, 0, 4'h0, 1, 1, 8'h62, 4'h0, 4'hB));
        tab_a.push_back(v(0, 1, 1, 2, 8'h78, 2, 0, 4'h0, 1, 1, 8'h62, 4'h0, 4'hB));
        tab_a.push_back(v(0, 1, 1, 2, 8'h79, 2, 0, 4'h0, 1, 1, 8'h62, 4'h0, 4'hB));
        tab_a.push_back(v(0, 1, 1, 2, 8'h7A, 2, 1, 4'h0, 0, 1, 8'h62, 4'h4, 4'hB));
        tab_a.push_back(v(0, 1, 0, 2, 8'h00, 2, 0, 4'h0, 1, 1, 8'h77, 4'h0, 4'hB));
        tab_a.push_back(v(0, 1, 1, 1, 8'h91, 1, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hB));
        tab_a.push_back(v(0, 1, 1, 1, 8'h92, 1, 0, 4'h0, 1, 1, 8'h91, 4'h0, 4'h9));
        tab_a.push_back(v(0, 1, 1, 1, 8'h93, 1, 0, 4'h0, 1, 1, 8'h91, 4'h0, 4'h9));
        tab_a.push_back(v(0, 1, 1, 0, 8'hC0, 1, 0, 4'h0, 1, 1, 8'h91, 4'h0, 4'h9));
        tab_a.push_back(v(0, 1, 1, 1, 8'h94, 1, 1, 4'h2, 0, 0, 8'h00, 4'h0, 4'h8));
        tab_a.push_back(v(0, 1, 0, 1, 8'h00, 1, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hA));
        tab_a.push_back(v(0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 1, 8'hC0, 4'h0, 4'hA));
        tab_a.push_back(v(0, 1, 0, 0, 8'h00, 2, 0, 4'h0, 1, 1, 8'h77, 4'h0, 4'hA));
        tab_a.push_back(v(1, 0, 0, 0, 8'h00, 2, 0, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0));
        tab_a.push_back(v(0, 1, 0, 0, 8'h00, 2, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF));

        tab_b.push_back(v(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0));
        tab_b.push_back(v(0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 1, 0, 8'h5A, 0, 1, 4'h0, 1, 1, 8'h5A, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 1, 0, 8'h5B, 0, 0, 4'h0, 1, 1, 8'h5B, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 1, 8'h5B, 4'h0, 4'h6));
        tab_b.push_back(v(0, 1, 1, 3, 8'hEE, 3, 1, 4'h0, 0, 0, 8'h00, 4'h0, 4'h6));
        tab_b.push_back(v(0, 1, 0, 0, 8'h00, 0, 1, 4'h0, 1, 1, 8'h5B, 4'h0, 4'h6));
        tab_b.push_back(v(0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 1, 1, 8'h66, 1, 1, 4'h2, 0, 0, 8'h00, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 0, 1, 8'h00, 1, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 1, 1, 8'h44, 0, 1, 4'h0, 1, 0, 8'h00, 4'h0, 4'h7));
        tab_b.push_back(v(0, 1, 0, 1, 8'h00, 1, 0, 4'h0, 1, 1, 8'h44, 4'h0, 4'h5));

        foreach (tab_a[i]) run(0, tab_a[i], $sformatf("a_vec%0d", i));

        // Ten push/pop pairs on ch0 walk the pointers around twice
        for (int i = 0; i < 10; i++) begin
            run(0, v(0, 1, 1, 0, 8'(8'hD0 + i), 0, 0, 4'h0, 1, 0, 8'h00, 4'h0, 4'hF),
                $sformatf("wrap_push%0d", i));
            run(0, v(0, 1, 0, 0, 8'h00, 0, 1, 4'h0, 1, 1, 8'(8'hD0 + i), 4'h0, 4'hE),
                $sformatf("wrap_pop%0d", i));
        end

        // Randomized traffic against per-channel queues
        for (int n = 0; n < 2000; n++) begin
            logic       e_ir, e_ov;
            logic [3:0] e_full, e_empty;
            a_rst = ($urandom_range(0, 199) == 0);
            a_iv  = ($urandom_range(0, 3) != 0);
            a_ic  = 2'($urandom_range(0, 3));
            a_id  = 8'($urandom_range(0, 255));
            a_oc  = 2'($urandom_range(0, 3));
            a_or  = ($urandom_range(0, 1) != 0);
            a_fl  = 4'h0;
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 39) == 0) a_fl[c] = 1'b1;
            e_ir = (q[a_ic].size() < 4) && !a_fl[a_ic];
            e_ov = (q[a_oc].size() > 0) && !a_fl[a_oc];
            for (int c = 0; c < 4; c++) begin
                e_full[c]  = (q[c].size() == 4);
                e_empty[c] = (q[c].size() == 0);
            end
            #1;
            chk($sformatf("rnd%0d.in_ready", n), 32'(a_ir), 32'(e_ir));
            chk($sformatf("rnd%0d.out_valid", n), 32'(a_ov), 32'(e_ov));
            if (e_ov) chk($sformatf("rnd%0d.out_data", n), 32'(a_od), 32'(q[a_oc][0]));
            chk($sformatf("rnd%0d.full", n), 32'(a_full), 32'(e_full));
            chk($sformatf("rnd%0d.empty", n), 32'(a_empty), 32'(e_empty));
            if (a_rst) begin
                for (int c = 0; c < 4; c++) q[c].delete();
            end else begin
                if (e_ov && a_or) void'(q[a_oc].pop_front());
                if (e_ir && a_iv) q[a_ic].push_back(a_id);
                for (int c = 0; c < 4; c++) if (a_fl[c]) q[c].delete();
            end
            @(posedge clk);
            #1;
        end
        a_rst = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_fl = 4'h0;

        foreach (tab_b[i]) run(1, tab_b[i], $sformatf("b_vec%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
